rb_access_arbiter: RTL

RB_ACCESS_ARBITER -- requirements
Module: rb_access_arbiter

---
 rtl/rb_access_arbiter_pkg.sv | 19 +
 rtl/rb_access_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rb_access_arbiter_pkg.sv
// Shared types and constants for the register-bank access arbiter.
// The optional idle-grant watchdog is enabled by defining RB_ARB_TIMEOUT_EN.
package rb_access_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_I2C  = 2'd1,
    GNT_UART = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  // 100 ms at 27 MHz
  localparam int DEFAULT_TIMEOUT_CYCLES = 2700000;
  localparam int WD_WIDTH               = 22;

  localparam logic LAST_I2C  = 1'b0;
  localparam logic LAST_UART = 1'b1;

endpackage

// File: rtl/rb_access_arbiter.sv
// Two-requester (I2C, UART) ownership arbiter in front of the register bank.
// Define RB_ARB_TIMEOUT_EN to add the idle-grant watchdog and requester blocking.
module rb_access_arbiter
  import rb_access_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_req,
  output logic       i2c_gnt,
  input  logic [7:0] i2c_address,
  input  logic [7:0] i2c_data_write,
  input  logic       i2c_reg_en,
  input  logic       i2c_write_en,
  input  logic       uart_req,
  output logic       uart_gnt,
  input  logic [7:0] uart_address,
  input  logic [7:0] uart_data_write,
  input  logic       uart_reg_en,
  input  logic       uart_write_en,
  output logic [7:0] rb_address,
  output logic [7:0] rb_data_write,
  output logic       rb_reg_en,
  output logic       rb_write_en,
  output logic [1:0] owner_mon,
  output logic       timeout_flag,
  output logic [7:0] denied_cnt
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << WD_WIDTH)) begin : g_bad_timeout
    $error("rb_access_arbiter: TIMEOUT_CYCLES out of range for the watchdog counter");
  end

  arb_state_t state_reg;
  logic       last_owner_reg;
  logic       i2c_gnt_reg;
  logic       uart_gnt_reg;
  logic [7:0] denied_cnt_reg;

  logic       i2c_eligible;
  logic       uart_eligible;
  logic       wd_fire;
  logic       i2c_denied;
  logic       uart_denied;
  logic [8:0] denied_sum;

`ifdef RB_ARB_TIMEOUT_EN
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] wd_cnt_reg;
  logic                i2c_block_reg;
  logic                uart_block_reg;
  logic                timeout_flag_reg;
  logic                owner_req;
  logic                owner_strobe;

  assign owner_req    = (state_reg == GNT_I2C  && i2c_req) ||
                        (state_reg == GNT_UART && uart_req);
  assign owner_strobe = (state_reg == GNT_I2C  && i2c_reg_en) ||
                        (state_reg == GNT_UART && uart_reg_en);

  // A requester that let its grant time out stays out until it drops req.
  assign i2c_eligible  = i2c_req  && !i2c_block_reg;
  assign uart_eligible = uart_req && !uart_block_reg;
  assign wd_fire       = owner_req && !owner_strobe && (wd_cnt_reg == WD_LIMIT);
  assign timeout_flag  = timeout_flag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg       <= '0;
      i2c_block_reg    <= 1'b0;
      uart_block_reg   <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      // Held at zero outside grants so every grant starts counting from zero.
      if (state_reg != GNT_I2C && state_reg != GNT_UART) begin
        wd_cnt_reg <= '0;
      end else if (owner_strobe) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + WD_WIDTH'(1);
      end

      if (wd_fire) begin
        timeout_flag_reg <= 1'b1;
      end

      if (!i2c_req) begin
        i2c_block_reg <= 1'b0;
      end else if (wd_fire && state_reg == GNT_I2C) begin
        i2c_block_reg <= 1'b1;
      end

      if (!uart_req) begin
        uart_block_reg <= 1'b0;
      end else if (wd_fire && state_reg == GNT_UART) begin
        uart_block_reg <= 1'b1;
      end
    end
  end
`else
  assign i2c_eligible  = i2c_req;
  assign uart_eligible = uart_req;
  assign wd_fire       = 1'b0;
  assign timeout_flag  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= LAST_UART;
      i2c_gnt_reg    <= 1'b0;
      uart_gnt_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie the requester not served last wins.
          if (i2c_eligible && (!uart_eligible || last_owner_reg == LAST_UART)) begin
            state_reg      <= GNT_I2C;
            last_owner_reg <= LAST_I2C;
            i2c_gnt_reg    <= 1'b1;
          end else if (uart_eligible) begin
            state_reg      <= GNT_UART;
            last_owner_reg <= LAST_UART;
            uart_gnt_reg   <= 1'b1;
          end
        end
        GNT_I2C: begin
          if (!i2c_req || wd_fire) begin
            state_reg   <= RELEASE;
            i2c_gnt_reg <= 1'b0;
          end
        end
        GNT_UART: begin
          if (!uart_req || wd_fire) begin
            state_reg    <= RELEASE;
            uart_gnt_reg <= 1'b0;
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg    <= IDLE;
          i2c_gnt_reg  <= 1'b0;
          uart_gnt_reg <= 1'b0;
        end
      endcase
    end
  end

  assign i2c_gnt   = i2c_gnt_reg;
  assign uart_gnt  = uart_gnt_reg;
  assign owner_mon = state_reg;

  always_comb begin
    rb_address    = 8'h00;
    rb_data_write = 8'h00;
    rb_reg_en     = 1'b0;
    rb_write_en   = 1'b0;
    case (state_reg)
      GNT_I2C: begin
        rb_address    = i2c_address;
        rb_data_write = i2c_data_write;
        rb_reg_en     = i2c_reg_en;
        rb_write_en   = i2c_write_en;
      end
      GNT_UART: begin
        rb_address    = uart_address;
        rb_data_write = uart_data_write;
        rb_reg_en     = uart_reg_en;
        rb_write_en   = uart_write_en;
      end
      default: ;
    endcase
  end

  // In IDLE/RELEASE both requesters are non-owners, so up to two strobes count.
  assign i2c_denied  = i2c_reg_en  && (state_reg != GNT_I2C);
  assign uart_denied = uart_reg_en && (state_reg != GNT_UART);
  assign denied_sum  = {1'b0, denied_cnt_reg} + {8'd0, i2c_denied} + {8'd0, uart_denied};

  always_ff @(posedge clk) begin
    if (reset) begin
      denied_cnt_reg <= 8'h00;
    end else if (denied_sum[8]) begin
      denied_cnt_reg <= 8'hFF;
    end else begin
      denied_cnt_reg <= denied_sum[7:0];
    end
  end

  assign denied_cnt = denied_cnt_reg;

endmodule
